// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO.
// Holds the default geometry and threshold constants, and the status record.
// The status record groups the flag and error outputs so they can be compared as one value.
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_AF_THRESH = DEFAULT_DEPTH - 2;
    localparam int DEFAULT_AE_THRESH = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_if.sv
// Handshake and status bundle between a producer/consumer and the FIFO.
// The master side drives the write/read requests and write data.
// The slave side (the FIFO) drives the read data, flags, count and error pulses.
interface fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);

    logic                       w_en;
    logic [WIDTH-1:0]           data_in;
    logic                       r_en;
    logic [WIDTH-1:0]           data_out;
    logic                       rd_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO.
// It has one synchronous write port and one asynchronous read port.
// The array has no reset: the contents are only meaningful between the pointers.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the write data on the clock edge when the write is enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with an occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow error pulses and a read-valid strobe.
// Build option SYNC_FIFO_FWFT_EN selects first-word-fall-through read data.
// When it is undefined, read data is registered on the accepting edge.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
    input  logic   clk,
    input  logic   rst,
    fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_THRESH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_acc;
    logic             wr_acc;
    fifo_status_t     status;
    logic [WIDTH-1:0] ram_rd_data;

    // Decode the flags from the count register and decide which requests are accepted.
    always_comb begin
        status              = '0;
        status.full         = (count_q == FULL_COUNT);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AF_COUNT);
        status.almost_empty = (count_q <= AE_COUNT);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
        rd_acc              = bus.r_en && !status.empty;
        wr_acc              = bus.w_en && (!status.full || rd_acc);
    end

    // Advance the pointers and occupancy, and flag dropped requests for the next cycle.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.w_en && !wr_acc;
        underflow_d = bus.r_en && status.empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer, count and error-pulse registers; reset discards the logical contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The head word is presented continuously; r_en only acknowledges it.
    always_comb begin
        bus.data_out = ram_rd_data;
        bus.rd_valid = !status.empty;
    end
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read, otherwise hold the last word.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            data_out_d = ram_rd_data;
        end
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        bus.data_out = data_out_q;
        bus.rd_valid = rd_valid_q;
    end
`endif

    // Drive the status outputs from the decoded record.
    always_comb begin
        bus.full         = status.full;
        bus.empty        = status.empty;
        bus.almost_full  = status.almost_full;
        bus.almost_empty = status.almost_empty;
        bus.overflow     = status.overflow;
        bus.underflow    = status.underflow;
        bus.count        = count_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH=8, WIDTH=8, AF_THRESH=6, AE_THRESH=2).
// Directed scenarios are followed by randomized traffic.
// Every cycle is compared against a queue-based reference model.
// Define SYNC_FIFO_FWFT_EN to check the first-word-fall-through build.
module tb_sync_fifo_flags;
    import sync_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk;
    logic rst;

    fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sync_fifo_flags #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the FIFO is a plain queue of the words it holds.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_over;
    logic             exp_under;

    int checks = 0;
    int errors = 0;

    // Compare one observed value against its required value and record the outcome.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model says it should be right now.
    task automatic checkState();
        int n;
        fifo_status_t exp_st;
        fifo_status_t obs_st;
        n = model_q.size();
        exp_st.full         = (n == DEPTH);
        exp_st.empty        = (n == 0);
        exp_st.almost_full  = (n >= AF);
        exp_st.almost_empty = (n <= AE);
        exp_st.overflow     = exp_over;
        exp_st.underflow    = exp_under;
        obs_st.full         = bus.full;
        obs_st.empty        = bus.empty;
        obs_st.almost_full  = bus.almost_full;
        obs_st.almost_empty = bus.almost_empty;
        obs_st.overflow     = bus.overflow;
        obs_st.underflow    = bus.underflow;
        checkOutput("status", 32'(obs_st), 32'(exp_st));
        checkOutput("count", 32'(bus.count), 32'(n));
        checkOutput("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
`ifdef SYNC_FIFO_FWFT_EN
        if (exp_valid) begin
            checkOutput("data_out", 32'(bus.data_out), 32'(model_q[0]));
        end
`else
        checkOutput("data_out", 32'(bus.data_out), 32'(exp_dout));
`endif
    endtask

    // Drive one cycle of requests, predict its effect, then check after the edge.
    task automatic applyStimulus(input logic w, input logic [WIDTH-1:0] d, input logic r);
        int  n;
        bit  rd_ok;
        bit  wr_ok;
        bus.w_en    = w;
        bus.data_in = d;
        bus.r_en    = r;
        n         = model_q.size();
        rd_ok     = r && (n > 0);
        wr_ok     = w && ((n < DEPTH) || rd_ok);
        exp_over  = w && !wr_ok;
        exp_under = r && (n == 0);
`ifdef SYNC_FIFO_FWFT_EN
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        exp_valid = (model_q.size() > 0);
`else
        if (rd_ok) exp_dout = model_q.pop_front();
        exp_valid = rd_ok;
        if (wr_ok) model_q.push_back(d);
`endif
        @(posedge clk);
        #1;
        checkState();
    endtask

    // Assert reset between clock edges, check the reset values, then release it.
    task automatic doReset();
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
        checkState();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        logic [WIDTH-1:0] d;
        rst         = 1'b1;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        exp_over    = 1'b0;
        exp_under   = 1'b0;

        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0);

        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("fill_count", 32'(bus.count), 32'd8);
        checkOutput("fill_full", 32'(bus.full), 32'd1);

        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("ovf_pulse", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.count), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b0);

        for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            checkOutput("fwft_head", 32'(bus.data_out), 32'(i));
`endif
            applyStimulus(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
            checkOutput("read_order", 32'(bus.data_out), 32'(i));
`endif
        end
        checkOutput("drain_empty", 32'(bus.empty), 32'd1);

        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("unf_pulse", 32'(bus.underflow), 32'd1);
        checkOutput("unf_count", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        checkOutput("unf_readback", 32'(bus.data_out), 32'h55);
`endif

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                doReset();
                for (int k = 0; k < 4; k++) begin
                    applyStimulus(1'b1, 8'($urandom), 1'b0);
                end
            end
            applyStimulus(1'b1, 8'($urandom), 1'b1);
            checkOutput("stream_count", 32'(bus.count), 32'd4);
        end

        for (int blk = 0; blk < 4; blk++) begin
            int wr_bias;
            wr_bias = (blk % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 80; i++) begin
                d = 8'($urandom);
                applyStimulus(($urandom_range(0, 99) < wr_bias),
                              d,
                              ($urandom_range(0, 99) >= wr_bias));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, overflow and underflow error pulses, and a read-valid strobe. It sits between any single-clock producer and consumer in the datapath. It uses the same `w_en`/`r_en` handshake, so existing `fifo_if`-based benches drive it unchanged.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `WIDTH`, 8: data width in bits, ≥1.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `w_en`  in  1  write request.
- `data_in`  in  WIDTH  write data.
- `r_en`  in  1  read request.
- `data_out`  out  WIDTH  read data.
- `rd_valid`  out  1  `data_out` carries a newly popped word.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_THRESH.
- `almost_empty`  out  1  count ≤ AE_THRESH.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: a write was dropped.
- `underflow`  out  1  one-cycle pulse: a read was dropped.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` is a separate register.
- Read accepted: `rd_acc = r_en && !empty`.
- Write accepted: `wr_acc = w_en && (!full || rd_acc)`. A write while full succeeds only if a read is accepted in the same cycle.
- Accepted write: `mem[wr_ptr] <= data_in`, then `wr_ptr++`. Accepted read: `rd_ptr++`.
- Count update: +1 for write only; −1 for read only; unchanged for both or neither.
- `overflow` pulses for one cycle on `w_en && !wr_acc`; the data is discarded and the state is unchanged.
- `underflow` pulses for one cycle on `r_en && empty`. This includes a simultaneous write into an empty FIFO: the write lands and the read is dropped.
- Status flags are combinational decodes of the `count` register only, never of the inputs.
- Reset, asserted at any time including mid-transfer, clears pointers and count, so the contents are logically lost. On reset:
  - `data_out` = 0, `rd_valid` = 0, `count` = 0.
  - `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
- Memory contents are not reset.

## Timing
- Write-to-flag latency: flags and `count` reflect an accepted write one cycle after the edge that sampled `w_en`.
- Read latency, standard mode: `data_out` is registered from `mem[rd_ptr]` on the accepting edge. `rd_valid` is 1 in the following cycle only. `data_out` holds its value when no read is accepted.
- Minimum fill-to-read: a word written at edge N can be read-accepted at edge N+1 and appears at N+1.
- `overflow` and `underflow` are registered, so they are high for exactly the cycle after the offending edge.
- Sustained throughput: one write plus one read per cycle at any occupancy from 1 to DEPTH.

## Configuration
- Macro: `SYNC_FIFO_FWFT_EN`.
- Undefined (default): standard mode as above.
- Defined: first-word-fall-through mode.
  - `data_out` = `mem[rd_ptr]` continuously, and `rd_valid` = `!empty`.
  - `r_en` acknowledges the presented word, with no added latency.
  - A word written at edge N is visible on `data_out` from edge N onward.
  - Reset value of `data_out` is don't-care while `rd_valid` = 0.
- All other behaviour is identical in both modes.

## Structure
- Package `sync_fifo_pkg`:
  - Holds the default parameter constants.
  - Holds the `fifo_status_t` packed struct: full, empty, almost_full, almost_empty, overflow, underflow. The bench uses it for scoreboard comparison.
- Sub-module `sync_fifo_ram`:
  - Parameters WIDTH and DEPTH.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- The top level holds the pointers, count, flag decode and error logic.

## Test plan
All scenarios use DEPTH=8, WIDTH=8, AF_THRESH=6, AE_THRESH=2, in both macro settings.
- Reset, then idle: `empty`=1, `almost_empty`=1, `count`=0, all other outputs 0.
- Write 0x01..0x08 on consecutive cycles:
  - `count` steps 1..8.
  - `almost_empty` drops at count 3.
  - `almost_full` rises at count 6.
  - `full` rises at count 8.
- Read eight times: `data_out` returns 0x01..0x08 in order, with `rd_valid` timing per mode. Afterwards `empty`=1.
- While full, assert `w_en` with 0xAA and `r_en` low: one `overflow` pulse, `count` stays 8, 0xAA is never read.
- While empty, assert `r_en` and `w_en` with 0x55 together: `underflow` pulses, `count`=1, and the next read returns 0x55.
- Simultaneous read and write for 20 cycles at count 4 (wrapping the pointers):
  - `count` stays 4.
  - Data order is preserved.
  - A `rst` pulse mid-stream returns all outputs to their reset values.
